uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

UART receive-side controller: deserialises 8N1 frames from the `rx` pin and presents each good byte with a one-cycle valid strobe. It decodes the command characters 'A'..'D' into a one-hot LED pattern and checks that they arrive in the cyclic order A→B→C→D→A. This is the receive end of the key-driven transmitter link. It sits between the board `rx` pin and the LED/status logic.

## Interface

Parameters:
- `CLK_FREQ`, 50_000_000: sys_clk frequency in Hz.
- `BAUD`, 9600: line rate.
- `BAUD_CNT_MAX`, CLK_FREQ/BAUD (integer division, 5208 at defaults): clocks per bit.
- `HALF`, BAUD_CNT_MAX/2 (2604 at defaults): mid-bit sample point.

Ports:
- `sys_clk` in 1: system clock. There is one clock; all logic is on its rising edge.
- `rst` in 1: reset. It is synchronous and active-high.
- `rx` in 1: asynchronous serial input. It idles high.
- `data_out` out 8: last good received byte.
- `data_valid` out 1: one-cycle pulse when `data_out` is updated.
- `frame_err` out 1: one-cycle pulse when a stop bit is sampled low.
- `seq_err` out 1: one-cycle pulse when a good byte is out of sequence or is not in 'A'..'D'.
- `busy_flag` out 1: high while a frame is being received.
- `led` out 4: one-hot pattern for the last command received.
- `err_cnt` out 8: saturating count of frame_err and seq_err events.

## Operation

- **Input synchroniser**
  - `rx` passes through 2 flops to give `rx_s`, plus one delay flop to give `rx_d`.
  - All three flops reset to 1.
  - A start edge is `rx_d`=1 and `rx_s`=0.
- **State machine:** IDLE, START, DATA, STOP.
  - `baud_cnt` counts 0..BAUD_CNT_MAX-1, then wraps to 0.
  - `bit_cnt` counts 0..7.
- **IDLE**
  - On a start edge, go to START with `baud_cnt`=0.
  - `busy_flag`=0 in IDLE only.
- **START**
  - At `baud_cnt`==HALF-1, sample `rx_s`.
  - If `rx_s`=1, this is a false start: go to IDLE.
  - At `baud_cnt`==BAUD_CNT_MAX-1, go to DATA with `bit_cnt`=0.
- **DATA**
  - At `baud_cnt`==HALF-1, shift `rx_s` into the shift register, LSB first: shift right, new bit enters bit 7.
  - At `baud_cnt`==BAUD_CNT_MAX-1, increment `bit_cnt`.
  - After bit 7 completes, go to STOP.
- **STOP**
  - At `baud_cnt`==HALF-1, sample `rx_s`, then go to IDLE immediately. Not waiting for the end of the stop bit allows resync.
  - If `rx_s`=1: load `data_out` from the shift register and pulse `data_valid`.
  - If `rx_s`=0: pulse `frame_err`; `data_out` is unchanged.
- **Command decode** (on `data_valid`)
  - Byte 0x41/0x42/0x43/0x44 sets `led` to 0001/0010/0100/1000.
  - Any other byte leaves `led` unchanged.
- **Sequence check**
  - The register `exp` resets to 0x41.
  - If the byte != `exp`, pulse `seq_err`.
  - If the byte is in 'A'..'D', set `exp` to its successor ('D'→'A'); this resyncs after an error.
  - Otherwise `exp` is unchanged.
- **`err_cnt`**
  - +1 per `frame_err` or `seq_err` pulse.
  - Saturates at 255.
  - The two pulses cannot coincide, so it increments by at most 1 per cycle.

## Timing

- **Reset values**
  - `data_out`=0x00, `led`=0000, `err_cnt`=0.
  - `data_valid`, `frame_err`, `seq_err`, `busy_flag` = 0.
  - State=IDLE, `exp`=0x41.
- **Reset mid-frame**
  - The frame is aborted with no pulses.
  - If `rx` is still low after reset, no start is detected until `rx` goes high and then falls again.
  - This holds after a line break too: the edge detector requires high→low.
- **Latency**
  - Start-edge detection occurs 3 cycles after the `rx` pin falls.
  - `data_valid`/`frame_err` rise 9·BAUD_CNT_MAX+HALF+1 cycles after START is entered (±1).
- **Decode outputs**
  - `led`, `seq_err` and `err_cnt` update in the cycle after `data_valid`.
  - `seq_err` is a one-cycle pulse in that cycle.
- **Back-to-back frames**
  - IDLE is re-entered half a bit before the nominal stop-bit end.
  - A next start bit arriving at the nominal boundary (within ±HALF/2) is received.
- **Pulse width:** `data_valid`, `frame_err` and `seq_err` are exactly 1 cycle wide.
- **Counter width:** `baud_cnt` width is $clog2(BAUD_CNT_MAX).

## Test plan

Use BAUD_CNT_MAX=16 (HALF=8) overrides for speed, plus one run at the defaults.

1. Send 0x41 → one `data_valid` with `data_out`=0x41; `led`=0001; `seq_err`=0; `busy_flag` high only during the frame.
2. Send A,B,C,D,A back-to-back with no idle gap → five `data_valid` pulses; `led` = 0001, 0010, 0100, 1000, 0001; `err_cnt`=0.
3. Drive `rx` low for HALF-2 cycles, then high → no `data_valid`, no `frame_err`; `busy_flag` returns to 0.
4. Send 0x42 with stop bit=0 → one `frame_err` pulse; `data_out` unchanged; `err_cnt`=1. Then hold `rx` low 3 bit-times, release, and send 0x41 → received correctly.
5. Send 'A', then 'C', then 'D', then 0x55:
   - On 'C': `seq_err`, `led`=0100, `err_cnt`=1.
   - On 'D': no error.
   - On 0x55: `seq_err`, `led` stays 1000, `err_cnt`=2.
   - Then 300 bytes of 0x00 → `err_cnt`=255.
6. Assert `rst` for 1 cycle during data bit 4 → `busy_flag`=0 and all outputs return to reset values. The next frame 0x44 gives `data_out`=0x44, `led`=1000, and `seq_err` (since `exp`=0x41).

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 8N1 UART receiver with 'A'..'D' command decode and order check.
// Ports: sys_clk, rst (sync, active-high), rx in; data_out, data_valid,
// frame_err, seq_err, busy_flag, led, err_cnt out.
module uart_rx_ctrl #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 9600,
  parameter int BAUD_CNT_MAX = CLK_FREQ / BAUD,
  parameter int HALF         = BAUD_CNT_MAX / 2
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       seq_err,
  output logic       busy_flag,
  output logic [3:0] led,
  output logic [7:0] err_cnt
);

  localparam int CW = $clog2(BAUD_CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [CW-1:0] baud_nxt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;

  logic       rx_m;
  logic       rx_s;
  logic       rx_d;
  logic [1:0] settle;
  logic       start_edge;

  logic [7:0] exp_chr;
  logic       is_cmd;
  logic       seq_bad;
  logic       err_inc;

  // The three line flops reset high, so for three cycles after reset they
  // still hold reset values rather than line samples. Edge detection waits
  // until they are all real, otherwise a line held low through reset would
  // look like a fresh high-to-low edge.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rx_m   <= 1'b1;
      rx_s   <= 1'b1;
      rx_d   <= 1'b1;
      settle <= 2'd0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
      if (settle != 2'd3)
        settle <= settle + 2'd1;
    end
  end

  assign start_edge = (settle == 2'd3) & rx_d & ~rx_s;

  assign baud_nxt = (baud_cnt == CNT_LAST) ? '0
                  : baud_cnt + CW'(1);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy_flag  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (start_edge) begin
            state     <= START;
            busy_flag <= 1'b1;
          end
        end
        START: begin
          baud_cnt <= baud_nxt;
          if (baud_cnt == CNT_MID && rx_s) begin
            state     <= IDLE;
            busy_flag <= 1'b0;
          end else if (baud_cnt == CNT_LAST) begin
            state   <= DATA;
            bit_cnt <= 3'd0;
          end
        end
        DATA: begin
          baud_cnt <= baud_nxt;
          if (baud_cnt == CNT_MID)
            shreg <= {rx_s, shreg[7:1]};
          if (baud_cnt == CNT_LAST) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              state <= STOP;
          end
        end
        STOP: begin
          baud_cnt <= baud_nxt;
          // Leave at mid stop bit so a following start edge is never missed.
          if (baud_cnt == CNT_MID) begin
            state     <= IDLE;
            busy_flag <= 1'b0;
            if (rx_s) begin
              data_out   <= shreg;
              data_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign is_cmd  = (data_out >= 8'h41) && (data_out <= 8'h44);
  assign seq_bad = data_valid && (data_out != exp_chr);
  assign err_inc = seq_bad | frame_err;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      led     <= 4'b0000;
      seq_err <= 1'b0;
      err_cnt <= 8'd0;
      exp_chr <= 8'h41;
    end else begin
      seq_err <= seq_bad;
      if (err_inc && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
      if (data_valid && is_cmd) begin
        exp_chr <= (data_out == 8'h44) ? 8'h41
                 : data_out + 8'd1;
        unique case (data_out)
          8'h41:   led <= 4'b0001;
          8'h42:   led <= 4'b0010;
          8'h43:   led <= 4'b0100;
          default: led <= 4'b1000;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench for uart_rx_ctrl with a byte-level model.
// Driver serialises frames on rx; a monitor checks each strobe it sees.
module tb_uart_rx_ctrl;

  localparam int BIT = 16;
  localparam int HB  = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       seq_err;
  logic       busy_flag;
  logic [3:0] led;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .BAUD_CNT_MAX(BIT),
    .HALF        (HB)
  ) dut (
    .sys_clk   (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .seq_err   (seq_err),
    .busy_flag (busy_flag),
    .led       (led),
    .err_cnt   (err_cnt)
  );

  typedef struct {
    logic       fe;
    logic [7:0] data;
    logic       seq;
    logic [3:0] led;
    logic [7:0] err;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [7:0] m_exp;
  logic [7:0] m_last;
  logic [7:0] m_err;
  logic [3:0] m_led;

  logic [7:0] abcda [5] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h41};

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t",
               name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_exp  = 8'h41;
    m_last = 8'h00;
    m_err  = 8'd0;
    m_led  = 4'b0000;
    q.delete();
  endtask

  // Byte-level reference: what a receiver of this frame must report.
  task automatic model_push(input logic [7:0] d, input logic stop);
    exp_t e;
    logic bad;
    if (stop) begin
      bad = (d != m_exp);
      if (d >= 8'h41 && d <= 8'h44) begin
        m_led = 4'(1 << (d - 8'h41));
        m_exp = (d == 8'h44) ? 8'h41 : d + 8'd1;
      end
      if (bad && m_err < 8'd255) m_err = m_err + 8'd1;
      m_last = d;
      e = '{fe: 1'b0, data: d, seq: bad, led: m_led, err: m_err};
    end else begin
      if (m_err < 8'd255) m_err = m_err + 8'd1;
      e = '{fe: 1'b1, data: m_last, seq: 1'b0, led: m_led, err: m_err};
    end
    q.push_back(e);
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop,
                      input int stop_len);
    model_push(d, stop);
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(d[i], BIT);
    hold(stop, stop_len);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 40 * BIT) begin
      @(negedge clk);
      k++;
    end
    check("drain", q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("rst_data_out", data_out, 8'h00);
    check("rst_led", led, 4'b0000);
    check("rst_err_cnt", err_cnt, 8'd0);
    check("rst_strobes", {data_valid, frame_err, seq_err}, 3'b000);
    check("rst_busy", busy_flag, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (data_valid || frame_err) begin
          if (q.size() == 0) begin
            check("unexpected_strobe", {data_valid, frame_err}, 2'b00);
          end else begin
            e = q.pop_front();
            check("strobe_kind", frame_err, e.fe);
            check("data_out", data_out, e.data);
            @(posedge clk);
            #1;
            check("strobe_width", {data_valid, frame_err}, 2'b00);
            check("seq_err", seq_err, e.seq);
            check("led", led, e.led);
            check("err_cnt", err_cnt, e.err);
            @(posedge clk);
            #1;
            check("seq_err_width", seq_err, 1'b0);
          end
        end else if (seq_err) begin
          check("spurious_seq_err", seq_err, 1'b0);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    rst = 1'b1;
    rx  = 1'b1;
    model_reset();
    do_reset();

    // Single good 'A'; busy only inside the frame.
    fork
      send(8'h41, 1'b1, BIT);
      begin
        repeat (5 * BIT) @(negedge clk);
        check("busy_in_frame", busy_flag, 1'b1);
      end
    join
    check("busy_after_frame", busy_flag, 1'b0);
    drain();
    check("t1_led", led, 4'b0001);

    // A,B,C,D,A with no idle gap.
    do_reset();
    for (int i = 0; i < 5; i++) send(abcda[i], 1'b1, BIT);
    drain();
    check("t2_err_cnt", err_cnt, 8'd0);
    check("t2_led", led, 4'b0001);

    // Short low glitch is a false start.
    do_reset();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_busy_high", busy_flag, 1'b1);
    repeat (HB - 6) @(negedge clk);
    rx = 1'b1;
    repeat (14) @(negedge clk);
    check("glitch_busy_low", busy_flag, 1'b0);
    repeat (2 * BIT) @(negedge clk);

    // Framing error, line break, then recovery.
    do_reset();
    send(8'h42, 1'b0, BIT);
    hold(1'b0, 3 * BIT);
    hold(1'b1, 2 * BIT);
    send(8'h41, 1'b1, BIT);
    drain();
    check("t4_err_cnt", err_cnt, 8'd1);
    check("t4_data_out", data_out, 8'h41);

    // Sequence errors and counter saturation.
    do_reset();
    send(8'h41, 1'b1, BIT);
    send(8'h43, 1'b1, BIT);
    send(8'h44, 1'b1, BIT);
    send(8'h55, 1'b1, BIT);
    drain();
    check("t5_err_cnt_2", err_cnt, 8'd2);
    for (int i = 0; i < 300; i++) send(8'h00, 1'b1, BIT);
    drain();
    check("t5_err_sat", err_cnt, 8'd255);
    check("t5_led", led, 4'b1000);

    // Reset during data bit 4 with the line low.
    hold(1'b0, BIT);
    for (int i = 0; i < 4; i++) hold(abcda[3][i], BIT);
    rx = abcda[3][4];
    repeat (HB) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("t6_busy", busy_flag, 1'b0);
    check("t6_led", led, 4'b0000);
    check("t6_err_cnt", err_cnt, 8'd0);
    check("t6_data_out", data_out, 8'h00);
    hold(1'b0, 2 * BIT);
    hold(1'b1, 3 * BIT);
    send(8'h44, 1'b1, BIT);
    drain();
    check("t6_led_after", led, 4'b1000);

    // Random frames with jittered stop length and occasional bad stop.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      logic [7:0] d;
      logic       st;
      int         sl;
      if ($urandom_range(0, 9) < 7)
        d = 8'($urandom_range(8'h41, 8'h44));
      else
        d = 8'($urandom);
      st = ($urandom_range(0, 9) != 0);
      sl = BIT - HB / 2 + int'($urandom_range(0, HB));
      send(d, st, sl);
      if (!st)
        hold(1'b1, BIT);
      else if ($urandom_range(0, 3) == 0)
        hold(1'b1, int'($urandom_range(1, 3 * BIT)));
    end
    drain();

    repeat (20) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
